// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared frame constants and FSM state type for the SPI target
package spi_pkg;

    localparam int FRAME_BITS  = 24;
    localparam int ADDR_BITS   = 8;
    localparam int DATA_BITS   = 16;
    localparam int RD_FLAG_BIT = 7;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        RDATA,
        DONE
    } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchroniser with level and edge pulses
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT        = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // shift the asynchronous input through the stages and keep a delayed copy for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{INIT}};
            prev_q <= INIT;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_target_regbank.sv
// rtl/spi_target_regbank.sv - SPI target frame decoder with parallel 16-bit register bank
module spi_target_regbank
    import spi_pkg::*;
#(
    parameter int                   NUM_REGS    = 16,
    parameter logic [DATA_BITS-1:0] RESET_VAL   = 16'h0000,
    parameter int                   SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sen,
    input  logic                     sclk,
    input  logic                     sdin,
    input  logic                     resetn,
    output logic                     sdout,
    output logic                     sdout_oe,
    output logic [16*NUM_REGS-1:0]   regs_flat,
    output logic                     wr_strobe,
    output logic [6:0]               wr_addr,
    output logic                     addr_err
);

    logic sen_lvl, sen_rise_unused, sen_fall_unused;
    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic sdin_lvl, sdin_rise_unused, sdin_fall_unused;
    logic resetn_lvl, resetn_rise_unused, resetn_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_sen (
        .clk(clk), .reset(reset), .d(sen),
        .level(sen_lvl), .rise(sen_rise_unused), .fall(sen_fall_unused)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sdin (
        .clk(clk), .reset(reset), .d(sdin),
        .level(sdin_lvl), .rise(sdin_rise_unused), .fall(sdin_fall_unused)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_resetn (
        .clk(clk), .reset(reset), .d(resetn),
        .level(resetn_lvl), .rise(resetn_rise_unused), .fall(resetn_fall_unused)
    );

    spi_state_t           state, state_next;
    logic [4:0]           bit_cnt;
    logic [DATA_BITS-1:0] in_sr, out_sr, rd_val;
    logic [DATA_BITS-1:0] regs [NUM_REGS];
    logic [ADDR_BITS-1:0] addr_next;
    logic [6:0]           next_idx, addr_idx;
    logic                 next_in_range, addr_in_range;
    logic                 cnt_clr, shift_en, decode, commit_set, drive_bit, commit_pend;

    // the address byte completes with the bit being sampled on the 8th rise
    assign addr_next     = {in_sr[ADDR_BITS-2:0], sdin_lvl};
    assign next_idx      = addr_next[6:0];
    assign next_in_range = (int'(next_idx) < NUM_REGS);
    assign addr_in_range = (int'(addr_idx) < NUM_REGS);

    // read mux: out-of-range indices return zero
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (next_idx == 7'(i)) rd_val = regs[i];
        end
    end

    // next-state and per-cycle control strobes; a high sen outside IDLE aborts the frame
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        decode     = 1'b0;
        commit_set = 1'b0;
        drive_bit  = 1'b0;
        case (state)
            IDLE: begin
                if (!sen_lvl) begin
                    cnt_clr    = 1'b1;
                    state_next = ADDR;
                end
            end
            ADDR: begin
                if (sclk_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 5'(ADDR_BITS - 1)) begin
                        decode     = 1'b1;
                        cnt_clr    = 1'b1;
                        state_next = addr_next[RD_FLAG_BIT] ? RDATA : WDATA;
                    end
                end
            end
            WDATA: begin
                if (sclk_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 5'(DATA_BITS - 1)) begin
                        commit_set = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            RDATA: begin
                if (sclk_fall) begin
                    if (bit_cnt == 5'(DATA_BITS)) state_next = DONE;
                    else drive_bit = 1'b1;
                end
            end
            DONE: begin
                if (sen_lvl) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (state != IDLE && sen_lvl) begin
            state_next = IDLE;
            shift_en   = 1'b0;
            decode     = 1'b0;
            commit_set = 1'b0;
            drive_bit  = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // bit counter, shift registers and serial output driver
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt     <= '0;
            in_sr       <= '0;
            out_sr      <= '0;
            addr_idx    <= '0;
            sdout       <= 1'b0;
            sdout_oe    <= 1'b0;
            addr_err    <= 1'b0;
            commit_pend <= 1'b0;
        end else begin
            if (cnt_clr)                    bit_cnt <= '0;
            else if (shift_en || drive_bit) bit_cnt <= bit_cnt + 5'd1;
            if (shift_en) in_sr <= {in_sr[DATA_BITS-2:0], sdin_lvl};
            if (decode) begin
                addr_idx <= next_idx;
                out_sr   <= rd_val;
            end else if (drive_bit) begin
                out_sr <= {out_sr[DATA_BITS-2:0], 1'b0};
            end
            if (state_next != RDATA) sdout <= 1'b0;
            else if (drive_bit)      sdout <= out_sr[DATA_BITS-1];
            sdout_oe    <= (state_next == RDATA);
            addr_err    <= decode & ~next_in_range;
            commit_pend <= commit_set;
        end
    end

    // register bank: soft reset beats a coincident commit, out-of-range commits are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            wr_strobe <= commit_pend && addr_in_range && resetn_lvl;
            if (commit_pend && addr_in_range) wr_addr <= addr_idx;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (!resetn_lvl)                                         regs[i] <= RESET_VAL;
                else if (commit_pend && addr_in_range && addr_idx == 7'(i)) regs[i] <= in_sr;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[16*g +: 16] = regs[g];
    end

endmodule

// File: tb/tb_spi_target_regbank.sv
// tb/tb_spi_target_regbank.sv - directed self-checking bench for spi_target_regbank
module tb_spi_target_regbank;
    import spi_pkg::*;

    localparam int          NR = 16;
    localparam logic [15:0] RV = 16'hBEEF;

    logic clk = 1'b0;
    logic reset, sen, sclk, sdin, resetn;
    logic sdout, sdout_oe, wr_strobe, addr_err;
    logic [6:0] wr_addr;
    logic [16*NR-1:0] regs_flat;

    int total = 0;
    int bad = 0;
    int strobes = 0;
    int errs = 0;
    int exp_strobes = 0;
    logic [6:0]  strobe_addr [64];
    logic [15:0] exp_regs [NR];
    logic [15:0] rd, oe_data;
    logic [7:0]  oe_addr;

    always #5 clk = ~clk;

    spi_target_regbank #(.NUM_REGS(NR), .RESET_VAL(RV), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sen(sen), .sclk(sclk), .sdin(sdin), .resetn(resetn),
        .sdout(sdout), .sdout_oe(sdout_oe), .regs_flat(regs_flat),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .addr_err(addr_err)
    );

    // log write strobes and address-error pulses
    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_addr[strobes[5:0]] <= wr_addr;
            strobes <= strobes + 1;
        end
        if (addr_err) errs <= errs + 1;
    end

    function automatic logic [16*NR-1:0] flat_exp();
        logic [16*NR-1:0] f;
        for (int i = 0; i < NR; i++) f[16*i +: 16] = exp_regs[i];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic half();
        repeat (5) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] a, input logic [15:0] d, input int nbits);
        logic [23:0] w;
        w = {a, d};
        for (int i = 0; i < nbits; i++) begin
            sdin = w[23-i];
            half();
            if (i >= 8) begin
                rd[23-i]      = sdout;
                oe_data[23-i] = sdout_oe;
            end else begin
                oe_addr[7-i] = sdout_oe;
            end
            sclk = 1'b1;
            half();
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] a, input logic [15:0] d, input int nbits, input int gap);
        rd = '0; oe_data = '0; oe_addr = '0;
        sen = 1'b0;
        half();
        send_bits(a, d, nbits);
        half();
        sen = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; sen = 1'b1; sclk = 1'b0; sdin = 1'b0; resetn = 1'b1;
        for (int i = 0; i < NR; i++) exp_regs[i] = RV;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_sdout",     sdout,     0);
        chk("rst_oe",        sdout_oe,  0);
        chk("rst_strobe",    wr_strobe, 0);
        chk("rst_addr_err",  addr_err,  0);
        chk("rst_wr_addr",   wr_addr,   0);
        chk("rst_regs",      regs_flat, flat_exp());

        frame(8'h03, 16'hA55A, 24, 30);
        exp_regs[3] = 16'hA55A; exp_strobes++;
        chk("wr3_strobes", strobes, exp_strobes);
        chk("wr3_addr",    strobe_addr[0], 3);
        chk("wr3_regs",    regs_flat, flat_exp());
        chk("wr3_no_err",  errs, 0);

        frame(8'h05, 16'h1234, 24, 30);
        exp_regs[5] = 16'h1234; exp_strobes++;
        frame(8'h85, 16'h0000, 24, 30);
        chk("rd5_data",    rd, 16'h1234);
        chk("rd5_oe_data", oe_data, 16'hFFFF);
        chk("rd5_oe_addr", oe_addr, 8'h00);
        chk("rd5_oe_end",  sdout_oe, 0);
        chk("rd5_strobes", strobes, exp_strobes);

        frame(8'h02, 16'h7777, 12, 30);
        chk("abort_strobes", strobes, exp_strobes);
        chk("abort_regs",    regs_flat, flat_exp());
        chk("abort_oe",      sdout_oe, 0);
        frame(8'h02, 16'h0F0F, 24, 30);
        exp_regs[2] = 16'h0F0F; exp_strobes++;
        chk("retry_strobes", strobes, exp_strobes);
        chk("retry_addr",    strobe_addr[2], 2);
        chk("retry_regs",    regs_flat, flat_exp());

        frame(8'h20, 16'hFFFF, 24, 30);
        chk("oor_wr_err",     errs, 1);
        chk("oor_wr_strobes", strobes, exp_strobes);
        chk("oor_wr_regs",    regs_flat, flat_exp());
        frame(8'hA0, 16'h0000, 24, 30);
        chk("oor_rd_err",  errs, 2);
        chk("oor_rd_data", rd, 16'h0000);

        for (int i = 0; i < 4; i++) begin
            frame(8'(i), 16'h1000 + 16'(i), 24, 30);
            exp_regs[i] = 16'h1000 + 16'(i); exp_strobes++;
        end
        chk("fill_regs",    regs_flat, flat_exp());
        chk("fill_strobes", strobes, exp_strobes);
        resetn = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < NR; i++) exp_regs[i] = RV;
        chk("soft_rst_regs", regs_flat, flat_exp());

        frame(8'h06, 16'hFFFF, 24, 30);
        exp_regs[6] = 16'hFFFF; exp_strobes++;
        rd = '0; oe_data = '0; oe_addr = '0;
        sen = 1'b0;
        half();
        send_bits(8'h86, 16'h0000, 12);
        half();
        chk("mid_rd_oe",    sdout_oe, 1);
        chk("mid_rd_sdout", sdout, 1);
        chk("mid_rd_bits",  rd[15:12], 4'hF);
        reset = 1'b1;
        @(negedge clk);
        chk("hard_rst_sdout", sdout, 0);
        chk("hard_rst_oe",    sdout_oe, 0);
        chk("hard_rst_state", 256'(dut.state), 256'(IDLE));
        reset = 1'b0;
        sen = 1'b1;
        repeat (30) @(negedge clk);
        for (int i = 0; i < NR; i++) exp_regs[i] = RV;
        chk("hard_rst_regs", regs_flat, flat_exp());

        frame(8'h07, 16'h1111, 24, 30);
        frame(8'h08, 16'h2222, 24, 30);
        exp_regs[7] = 16'h1111; exp_regs[8] = 16'h2222; exp_strobes += 2;
        chk("b2b_strobes", strobes, exp_strobes);
        chk("b2b_first",   strobe_addr[8], 7);
        chk("b2b_second",  strobe_addr[9], 8);
        chk("b2b_regs",    regs_flat, flat_exp());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
